// File: rtl/regfile_exec_pkg.sv
// Shared types and constants for the register-file execute controller.
// The shifter opcodes are only legal when REGFILE_EXEC_SHIFT_EN is defined.
package regfile_exec_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int AW_DEF    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    localparam logic [3:0] OP_LAST_LEGAL = OP_SRA;

endpackage

// File: rtl/regfile_exec_alu.sv
// Combinational ALU for the execute controller.
// REGFILE_EXEC_SHIFT_EN adds SLL/SRL/SRA; without it those opcodes flag illegal.
module regfile_exec_alu
    import regfile_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef REGFILE_EXEC_SHIFT_EN
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $signed(a) >>> b[4:0];
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_exec_ctrl.sv
// Fetch/execute/write-back controller driving a 2R1W register file, one command per 4 cycles.
// Optional shifter opcodes via REGFILE_EXEC_SHIFT_EN (see regfile_exec_alu).
module regfile_exec_ctrl
    import regfile_exec_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [AW-1:0]    cmd_rd,
    output logic [AW-1:0]    rf_ra0,
    output logic [AW-1:0]    rf_ra1,
    input  logic [WIDTH-1:0] rf_rd0,
    input  logic [WIDTH-1:0] rf_rd1,
    output logic [AW-1:0]    rf_wa,
    output logic             rf_we,
    output logic [WIDTH-1:0] rf_wd,
    output logic             done_valid,
    output logic [WIDTH-1:0] done_result,
    output logic             done_err
);

    state_t           state_q;
    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] opa_q, opb_q;
    logic             ready_q, we_q, dv_q, derr_q;
    logic [AW-1:0]    ra0_q, ra1_q, wa_q;
    logic [WIDTH-1:0] wd_q, dres_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    regfile_exec_alu #(.WIDTH(WIDTH)) u_alu (
        .op      (op_q),
        .a       (opa_q),
        .b       (opb_q),
        .result  (alu_res),
        .illegal (alu_ill)
    );

    // Write-back outputs are loaded on the EXEC->WB edge so they are valid for exactly the WB cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            ready_q <= 1'b1;
            ra0_q   <= '0;
            ra1_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            dv_q    <= 1'b0;
            dres_q  <= '0;
            derr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op;
                        rd_q    <= cmd_rd;
                        ra0_q   <= cmd_rs1;
                        ra1_q   <= cmd_rs2;
                        ready_q <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    opa_q   <= rf_rd0;
                    opb_q   <= rf_rd1;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    we_q    <= !alu_ill && (rd_q != '0);
                    wa_q    <= rd_q;
                    wd_q    <= alu_res;
                    dv_q    <= 1'b1;
                    dres_q  <= alu_res;
                    derr_q  <= alu_ill;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    we_q    <= 1'b0;
                    dv_q    <= 1'b0;
                    derr_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign rf_ra0      = ra0_q;
    assign rf_ra1      = ra1_q;
    assign rf_we       = we_q;
    assign rf_wa       = wa_q;
    assign rf_wd       = wd_q;
    assign done_valid  = dv_q;
    assign done_result = dres_q;
    assign done_err    = derr_q;

endmodule

// File: doc/regfile_exec_ctrl.md
Name: regfile_exec_ctrl

Overview:
- Sequential operand-fetch / execute / write-back controller that sits directly upstream of register_file and drives all of its ports.
- Accepts one register-register command (op, rs1, rs2, rd) per valid/ready handshake.
- Reads both operands through the two regfile read ports, computes a 32-bit ALU result, and writes it back through the write port.
- Reports completion on a one-cycle done pulse. Used as the lab-2 datapath driver for register_file bring-up.

Parameters:
- WIDTH, 32, data width; must match register_file width.
- AW, 5, register address width (32 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  4  ALU opcode.
- cmd_rs1  in  AW  source register 1.
- cmd_rs2  in  AW  source register 2.
- cmd_rd  in  AW  destination register.
- rf_ra0  out  AW  to register_file.ra0.
- rf_ra1  out  AW  to register_file.ra1.
- rf_rd0  in  WIDTH  from register_file.rd0 (asynchronous read).
- rf_rd1  in  WIDTH  from register_file.rd1.
- rf_wa  out  AW  to register_file.wa.
- rf_we  out  1  to register_file.we.
- rf_wd  out  WIDTH  to register_file.wd.
- done_valid  out  1  one-cycle completion pulse.
- done_result  out  WIDTH  result of the completed command.
- done_err  out  1  completed command had an illegal opcode.

Behaviour:
- Clock is clk only; reset is synchronous and active-high on rst. Reset overrides everything, including a command in flight, which is dropped with no write and no done pulse.
- Reset values:
  - state = IDLE, cmd_ready = 1.
  - rf_we = 0, done_valid = 0, done_err = 0.
  - done_result = 0, rf_wd = 0, rf_wa = 0, rf_ra0 = 0, rf_ra1 = 0.
  - All internal operand and command registers = 0.
- FSM states and transitions:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready at an edge, capture op/rs1/rs2/rd and go to FETCH.
  - FETCH: rf_ra0 = rs1, rf_ra1 = rs2 (registered). Latch rf_rd0/rf_rd1 into opA/opB at the end of the cycle, then go to EXEC.
  - EXEC: compute the result into a register; set err if the opcode is illegal; go to WB.
  - WB: for one cycle, rf_we = !err && (rd != 0), rf_wa = rd, rf_wd = result, done_valid = 1, done_result = result, done_err = err. Then go to IDLE.
- cmd_ready is 0 in FETCH, EXEC and WB. A cmd_valid presented then is ignored and must be held by the source.
- Latency: handshake edge N; done_valid and rf_we high during cycle N+3. Throughput is 1 command per 4 cycles. The regfile write lands at the edge ending WB.
- Opcodes (mod 2^WIDTH, no flags):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed, result 0/1), 6 SLTU (result 0/1).
  - 7 SLL, 8 SRL, 9 SRA: shift amount is opB[4:0].
  - 10-15 illegal: result 0, err = 1, no write.
- Register x0: a write with rd = 0 is suppressed (rf_we = 0). done_valid still pulses with the computed result.
- Hazards:
  - Back-to-back dependent commands (rd of command k = rs of command k+1) see the updated value, because the write completes before the next FETCH.
  - rs1 == rs2 is legal.
  - rs == rd is legal: the old value is read in FETCH, the new value is written in WB.
- rf_we is never high outside WB.

Optional Feature:
- Macro: REGFILE_EXEC_SHIFT_EN.
- Defined: opcodes 7-9 perform SLL/SRL/SRA as above.
- Undefined: no shifter is synthesized. Opcodes 7-9 are illegal (err = 1, result 0, no regfile write). All other opcodes are unchanged.

Decomposition:
- Package regfile_exec_pkg holds:
  - the state encoding (IDLE/FETCH/EXEC/WB);
  - the opcode constants OP_ADD through OP_SRA;
  - OP_LAST_LEGAL;
  - the defaults for WIDTH and AW.
- One combinational sub-module, regfile_exec_alu (op, a, b -> result, illegal), contains the REGFILE_EXEC_SHIFT_EN guard. The FSM and handshake stay in the top module.

Test Plan:
- Reset, then write init: assert rst 2 cycles -> cmd_ready = 1, rf_we = 0, done_valid = 0. Preload r3 = 0x12345678 and r18 = 0x87654321 by direct regfile commands (ADD rs1 = 0, rs2 = 0 is not usable; use a testbench-forced regfile).
- ADD op=0, rs1 = 3, rs2 = 18, rd = 5 -> done_valid at N+3, result 0x99999999, rf_we = 1, rf_wa = 5. A later read of r5 returns 0x99999999.
- Dependent chain: SUB r6 = r5 - r3 immediately followed by XOR r7 = r6 ^ r18:
  - r6 = 0x87654321.
  - r7 = 0x00000000.
  - cmd_ready low for 3 cycles after each accept.
- x0 and illegal opcodes:
  - OR rd = 0 -> done_valid = 1, rf_we = 0.
  - op = 12 -> done_err = 1, result 0, rf_we = 0.
- Shift/SLT: SRA with r18 = 0x87654321 and shift 4 -> 0xF8765432 when the macro is defined; done_err = 1 when undefined. SLT with r18 vs r3 -> 1.
- Mid-operation reset: assert rst in EXEC -> the next cycle is IDLE, no rf_we and no done_valid for that command, and the regfile contents are unchanged.
